// File: rtl/dhs_apb_cmd_bridge.sv
// UART-byte-stream to APB master bridge: one framed command ('W'/'R') per single-beat APB transfer.
// Optional ACCESS-phase timeout is compiled in with `define DHS_APB_TIMEOUT_EN.
module dhs_apb_cmd_bridge #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                clk_i,
  input  logic                srst_i,
  input  logic [7:0]          rx_data_i,
  input  logic                rx_valid_i,
  output logic                rx_ready_o,
  output logic [7:0]          tx_data_o,
  output logic                tx_valid_o,
  input  logic                tx_ready_i,
  output logic                psel_o,
  output logic                penable_o,
  output logic [ADDR_W-1:0]   paddr_o,
  output logic                pwrite_o,
  output logic [DATA_W-1:0]   pwdata_o,
  output logic [DATA_W/8-1:0] pstrb_o,
  input  logic                pready_i,
  input  logic [DATA_W-1:0]   prdata_i,
  input  logic                pslverr_i,
  output logic                busy_o
);

  localparam int         STRB_W     = DATA_W / 8;
  localparam logic [7:0] ADDR_LAST  = 8'(ADDR_W / 8 - 1);
  localparam logic [7:0] DATA_LAST  = 8'(DATA_W / 8 - 1);
  localparam logic [7:0] DATA_BYTES = 8'(DATA_W / 8);
  localparam logic [7:0] OP_WRITE   = 8'h57;
  localparam logic [7:0] OP_READ    = 8'h52;
  localparam logic [7:0] ST_OK      = 8'h4B;
  localparam logic [7:0] ST_ERR     = 8'h45;
  localparam logic [7:0] ST_BADOP   = 8'h3F;

  if (ADDR_W < 8 || ADDR_W % 8 != 0 || DATA_W < 8 || DATA_W % 8 != 0 || TIMEOUT_CYCLES < 1)
  begin : g_bad_cfg
    $error("dhs_apb_cmd_bridge: unsupported parameter set");
  end

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_WDATA, S_SETUP, S_ACCESS, S_RESP} state_t;

  state_t              state_q, state_d;
  logic [7:0]          cnt_q, cnt_d;
  logic                rx_ready_q, rx_ready_d;
  logic [7:0]          tx_data_q, tx_data_d;
  logic                tx_valid_q, tx_valid_d;
  logic                psel_q, psel_d;
  logic                penable_q, penable_d;
  logic [ADDR_W-1:0]   paddr_q, paddr_d;
  logic                pwrite_q, pwrite_d;
  logic [DATA_W-1:0]   pwdata_q, pwdata_d;
  logic [STRB_W-1:0]   pstrb_q, pstrb_d;
  logic                busy_q, busy_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                rd_resp_q, rd_resp_d;
  logic                rx_fire, tx_fire;
  logic [ADDR_W-1:0]   addr_shift;
  logic [DATA_W-1:0]   data_shift;

`ifdef DHS_APB_TIMEOUT_EN
  localparam int            TO_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]    ST_TOUT = 8'h54;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
`endif

  assign rx_fire = rx_ready_q && rx_valid_i;
  assign tx_fire = tx_valid_q && tx_ready_i;

  // Little-endian fields: each new byte enters at the top and slides toward bit 0.
  assign addr_shift = (paddr_q >> 8) | (ADDR_W'(rx_data_i) << (ADDR_W - 8));
  assign data_shift = (pwdata_q >> 8) | (DATA_W'(rx_data_i) << (DATA_W - 8));

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    psel_d     = psel_q;
    penable_d  = penable_q;
    paddr_d    = paddr_q;
    pwrite_d   = pwrite_q;
    pwdata_d   = pwdata_q;
    pstrb_d    = pstrb_q;
    rdata_d    = rdata_q;
    rd_resp_d  = rd_resp_q;
`ifdef DHS_APB_TIMEOUT_EN
    to_cnt_d   = to_cnt_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (rx_fire) begin
          if (rx_data_i == OP_WRITE || rx_data_i == OP_READ) begin
            pwrite_d = (rx_data_i == OP_WRITE);
            state_d  = S_ADDR;
          end else begin
            tx_data_d  = ST_BADOP;
            tx_valid_d = 1'b1;
            rd_resp_d  = 1'b0;
            state_d    = S_RESP;
          end
        end
      end
      S_ADDR: begin
        if (rx_fire) begin
          paddr_d = addr_shift;
          cnt_d   = cnt_q + 8'd1;
          if (cnt_q == ADDR_LAST) state_d = pwrite_q ? S_WDATA : S_SETUP;
        end
      end
      S_WDATA: begin
        if (rx_fire) begin
          pwdata_d = data_shift;
          cnt_d    = cnt_q + 8'd1;
          if (cnt_q == DATA_LAST) state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        psel_d    = 1'b1;
        penable_d = 1'b0;
        pstrb_d   = pwrite_q ? {STRB_W{1'b1}} : '0;
`ifdef DHS_APB_TIMEOUT_EN
        to_cnt_d  = '0;
`endif
        state_d   = S_ACCESS;
      end
      S_ACCESS: begin
        // First ACCESS cycle only raises penable; pready is honoured once penable is visible.
        if (!penable_q) begin
          penable_d = 1'b1;
        end else if (pready_i) begin
          psel_d     = 1'b0;
          penable_d  = 1'b0;
          pstrb_d    = '0;
          tx_data_d  = pslverr_i ? ST_ERR : ST_OK;
          tx_valid_d = 1'b1;
          rdata_d    = prdata_i;
          rd_resp_d  = !pwrite_q;
          state_d    = S_RESP;
        end
`ifdef DHS_APB_TIMEOUT_EN
        else if (to_cnt_q == TO_LAST) begin
          psel_d     = 1'b0;
          penable_d  = 1'b0;
          pstrb_d    = '0;
          tx_data_d  = ST_TOUT;
          tx_valid_d = 1'b1;
          rdata_d    = '0;
          rd_resp_d  = !pwrite_q;
          state_d    = S_RESP;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
`endif
      end
      S_RESP: begin
        if (tx_fire) begin
          if (rd_resp_q && cnt_q != DATA_BYTES) begin
            tx_data_d = rdata_q[7:0];
            rdata_d   = rdata_q >> 8;
            cnt_d     = cnt_q + 8'd1;
          end else begin
            tx_valid_d = 1'b0;
            state_d    = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (state_d != state_q) cnt_d = '0;
  end

  assign rx_ready_d = (state_d == S_IDLE) || (state_d == S_ADDR) || (state_d == S_WDATA);
  assign busy_d     = (state_d != S_IDLE);

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      rx_ready_q <= 1'b1;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      psel_q     <= 1'b0;
      penable_q  <= 1'b0;
      paddr_q    <= '0;
      pwrite_q   <= 1'b0;
      pwdata_q   <= '0;
      pstrb_q    <= '0;
      busy_q     <= 1'b0;
      rdata_q    <= '0;
      rd_resp_q  <= 1'b0;
`ifdef DHS_APB_TIMEOUT_EN
      to_cnt_q   <= '0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rx_ready_q <= rx_ready_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      psel_q     <= psel_d;
      penable_q  <= penable_d;
      paddr_q    <= paddr_d;
      pwrite_q   <= pwrite_d;
      pwdata_q   <= pwdata_d;
      pstrb_q    <= pstrb_d;
      busy_q     <= busy_d;
      rdata_q    <= rdata_d;
      rd_resp_q  <= rd_resp_d;
`ifdef DHS_APB_TIMEOUT_EN
      to_cnt_q   <= to_cnt_d;
`endif
    end
  end

  assign rx_ready_o = rx_ready_q;
  assign tx_data_o  = tx_data_q;
  assign tx_valid_o = tx_valid_q;
  assign psel_o     = psel_q;
  assign penable_o  = penable_q;
  assign paddr_o    = paddr_q;
  assign pwrite_o   = pwrite_q;
  assign pwdata_o   = pwdata_q;
  assign pstrb_o    = pstrb_q;
  assign busy_o     = busy_q;

endmodule

// File: tb/tb_dhs_apb_cmd_bridge.sv
// Self-checking bench for dhs_apb_cmd_bridge: frame-level reference model, behavioural APB slave, UART byte sink.
module tb_dhs_apb_cmd_bridge;

`ifdef DHS_APB_TIMEOUT_EN
  localparam int TO = 8;
`else
  localparam int TO = 1024;
`endif

  typedef logic [7:0] bq_t[$];

  logic        clk = 1'b0;
  logic        srst = 1'b1;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        rx_ready_o;
  logic [7:0]  tx_data_o;
  logic        tx_valid_o;
  logic        tx_ready = 1'b0;
  logic        psel_o, penable_o, pwrite_o, busy_o;
  logic [31:0] paddr_o, pwdata_o;
  logic [3:0]  pstrb_o;
  logic        pready = 1'b0;
  logic [31:0] prdata = 32'h0;
  logic        pslverr = 1'b0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dhs_apb_cmd_bridge #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(TO)) dut (
    .clk_i(clk), .srst_i(srst),
    .rx_data_i(rx_data), .rx_valid_i(rx_valid), .rx_ready_o(rx_ready_o),
    .tx_data_o(tx_data_o), .tx_valid_o(tx_valid_o), .tx_ready_i(tx_ready),
    .psel_o(psel_o), .penable_o(penable_o), .paddr_o(paddr_o), .pwrite_o(pwrite_o),
    .pwdata_o(pwdata_o), .pstrb_o(pstrb_o), .pready_i(pready), .prdata_i(prdata),
    .pslverr_i(pslverr), .busy_o(busy_o)
  );

  // Behavioural APB slave: answers after slv_wait penable cycles unless slv_hang; records each transfer.
  int          slv_wait = 0;
  bit          slv_hang = 1'b0;
  logic [31:0] slv_rdata = 32'h0;
  logic        slv_err = 1'b0;
  int          acc_cnt = 0, cur_psel = 0, cur_pen = 0, last_psel = 0, last_pen = 0, n_xfer = 0;
  bit          in_xfer = 1'b0, unstable = 1'b0;
  logic [31:0] obs_addr, obs_wdata;
  logic [3:0]  obs_strb;
  logic        obs_write;

  always @(negedge clk) begin
    if (psel_o) begin
      if (!in_xfer) begin
        in_xfer = 1'b1; cur_psel = 0; cur_pen = 0; unstable = 1'b0;
        obs_addr = paddr_o; obs_wdata = pwdata_o; obs_strb = pstrb_o; obs_write = pwrite_o;
      end else if (paddr_o !== obs_addr || pwdata_o !== obs_wdata || pstrb_o !== obs_strb || pwrite_o !== obs_write) begin
        unstable = 1'b1;
      end
      cur_psel++;
      if (penable_o) begin
        cur_pen++;
        if (!slv_hang && acc_cnt == slv_wait) begin
          pready = 1'b1; prdata = slv_rdata; pslverr = slv_err;
        end else begin
          pready = 1'b0; prdata = $urandom; pslverr = 1'($urandom_range(0, 1));
        end
        acc_cnt++;
      end else begin
        pready = 1'b0; acc_cnt = 0;
      end
    end else begin
      if (in_xfer) begin
        in_xfer = 1'b0; n_xfer++; last_psel = cur_psel; last_pen = cur_pen;
      end
      pready = 1'b0; acc_cnt = 0;
    end
  end

  function automatic bq_t build(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] data);
    bq_t q;
    q.push_back(op);
    if (op == 8'h57 || op == 8'h52) begin
      for (int i = 0; i < 4; i++) q.push_back(8'((addr >> (8 * i)) & 32'hFF));
      if (op == 8'h57) for (int i = 0; i < 4; i++) q.push_back(8'((data >> (8 * i)) & 32'hFF));
    end
    return q;
  endfunction

  // Expected response bytes for a whole frame.
  function automatic bq_t model(input logic [7:0] op, input logic [31:0] rdata, input bit err, input bit tout);
    bq_t q;
    if (op != 8'h57 && op != 8'h52) begin
      q.push_back(8'h3F);
      return q;
    end
    q.push_back(tout ? 8'h54 : (err ? 8'h45 : 8'h4B));
    if (op == 8'h52)
      for (int i = 0; i < 4; i++) q.push_back(tout ? 8'h00 : 8'((rdata >> (8 * i)) & 32'hFF));
    return q;
  endfunction

  // Called at a negedge; returns at the negedge following acceptance of the last byte.
  task automatic send_bytes(input bq_t b);
    foreach (b[i]) begin
      int budget = 200;
      rx_data = b[i]; rx_valid = 1'b1;
      while (!rx_ready_o && budget > 0) begin @(negedge clk); budget--; end
      checks++;
      if (budget == 0) begin
        failures++;
        $display("FAIL rx_accept: byte %0d (%02h) not accepted within 200 cycles, rx_ready=%b, required 1", i, b[i], rx_ready_o);
      end
      @(negedge clk);
    end
    rx_valid = 1'b0;
  endtask

  task automatic collect(input int n, input int stall, output bq_t got);
    int waited = 0;
    int budget = 4000;
    logic [7:0] held = 8'h00;
    got = {};
    while (got.size() < n && budget > 0) begin
      @(negedge clk); budget--;
      if (tx_valid_o) begin
        if (waited == 0) held = tx_data_o;
        else begin
          checks++;
          if (tx_data_o !== held) begin
            failures++;
            $display("FAIL tx_hold: tx_data=%02h while stalled, required %02h", tx_data_o, held);
          end
        end
        if (waited >= stall) begin tx_ready = 1'b1; got.push_back(tx_data_o); waited = 0; end
        else begin tx_ready = 1'b0; waited++; end
      end else begin
        tx_ready = 1'b0;
      end
    end
    checks++;
    if (got.size() < n) begin
      failures++;
      $display("FAIL resp_timeout: got %0d response bytes, required %0d", got.size(), n);
    end
    @(negedge clk);
    tx_ready = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    srst = 1'b0;
    checks++;
    if ({rx_ready_o, tx_valid_o, psel_o, penable_o, pwrite_o, busy_o} !== 6'b100000) begin
      failures++;
      $display("FAIL reset_ctrl: {rx_rdy,tx_vld,psel,pen,pwr,busy}=%b, required 100000",
               {rx_ready_o, tx_valid_o, psel_o, penable_o, pwrite_o, busy_o});
    end
    checks++;
    if ({paddr_o, pwdata_o, pstrb_o, tx_data_o} !== 76'h0) begin
      failures++;
      $display("FAIL reset_data: paddr=%h pwdata=%h pstrb=%h tx_data=%h, required all 0", paddr_o, pwdata_o, pstrb_o, tx_data_o);
    end
    $display("txn reset done");
  endtask

  task automatic test_write();
    bq_t got, exp;
    int n0 = n_xfer;
    slv_wait = 0; slv_hang = 1'b0; slv_err = 1'b0;
    exp = model(8'h57, 32'h0, 1'b0, 1'b0);
    send_bytes(build(8'h57, 32'h8000_0000, 32'hDEAD_BEEF));
    checks++;
    if ({psel_o, rx_ready_o, busy_o} !== 3'b001) begin
      failures++; $display("FAIL wr_n0: {psel,rx_rdy,busy}=%b, required 001", {psel_o, rx_ready_o, busy_o});
    end
    @(negedge clk);
    checks++;
    if ({psel_o, penable_o, pwrite_o, pstrb_o} !== 7'b101_1111) begin
      failures++; $display("FAIL wr_setup: {psel,pen,pwr,pstrb}=%b, required 1011111", {psel_o, penable_o, pwrite_o, pstrb_o});
    end
    @(negedge clk);
    checks++;
    if ({psel_o, penable_o} !== 2'b11) begin
      failures++; $display("FAIL wr_access: {psel,pen}=%b, required 11", {psel_o, penable_o});
    end
    @(negedge clk);
    checks++;
    if ({psel_o, penable_o, tx_valid_o, tx_data_o} !== {3'b001, 8'h4B}) begin
      failures++; $display("FAIL wr_n3: psel=%b pen=%b tx_valid=%b tx_data=%02h, required 0 0 1 4b", psel_o, penable_o, tx_valid_o, tx_data_o);
    end
    collect(1, 0, got);
    checks++;
    if (got.size() != 1 || got[0] !== 8'h4B) begin
      failures++; $display("FAIL wr_resp: got %p, required %p", got, exp);
    end
    checks++;
    if (obs_addr !== 32'h8000_0000 || obs_wdata !== 32'hDEAD_BEEF || obs_strb !== 4'hF || obs_write !== 1'b1) begin
      failures++; $display("FAIL wr_apb: addr=%h wdata=%h strb=%h write=%b, required 80000000 deadbeef f 1", obs_addr, obs_wdata, obs_strb, obs_write);
    end
    checks++;
    if (last_psel != 2 || last_pen != 1 || unstable || n_xfer != n0 + 1) begin
      failures++; $display("FAIL wr_psel: psel_cyc=%0d pen_cyc=%0d unstable=%b xfers=%0d, required 2 1 0 %0d", last_psel, last_pen, unstable, n_xfer - n0, 1);
    end
    checks++;
    if ({tx_valid_o, rx_ready_o, busy_o} !== 3'b010) begin
      failures++; $display("FAIL wr_idle: {tx_vld,rx_rdy,busy}=%b, required 010", {tx_valid_o, rx_ready_o, busy_o});
    end
    $display("txn write addr=80000000 data=deadbeef resp=%p", got);
  endtask

  task automatic test_read();
    bq_t got, exp;
    slv_wait = 3; slv_hang = 1'b0; slv_err = 1'b0; slv_rdata = 32'h1234_5678;
    exp = model(8'h52, slv_rdata, 1'b0, 1'b0);
    send_bytes(build(8'h52, 32'h8000_0004, 32'h0));
    collect(5, 0, got);
    checks++;
    if (got != exp) begin failures++; $display("FAIL rd_resp: got %p, required %p", got, exp); end
    checks++;
    if (obs_addr !== 32'h8000_0004 || obs_strb !== 4'h0 || obs_write !== 1'b0 || last_pen != 4 || unstable) begin
      failures++; $display("FAIL rd_apb: addr=%h strb=%h write=%b pen_cyc=%0d unstable=%b, required 80000004 0 0 4 0", obs_addr, obs_strb, obs_write, last_pen, unstable);
    end
    $display("txn read addr=80000004 resp=%p", got);
  endtask

  task automatic test_error_backpressure();
    bq_t got, exp;
    logic [31:0] a = $urandom;
    slv_wait = $urandom_range(0, 2); slv_err = 1'b1; slv_rdata = 32'hA5A5_A5A5;
    exp = model(8'h52, slv_rdata, 1'b1, 1'b0);
    send_bytes(build(8'h52, a, 32'h0));
    collect(5, 5, got);
    checks++;
    if (got != exp) begin failures++; $display("FAIL err_resp: got %p, required %p", got, exp); end
    checks++;
    if (obs_addr !== a) begin failures++; $display("FAIL err_addr: paddr=%h, required %h", obs_addr, a); end
    slv_err = 1'b0;
    $display("txn read_err addr=%h resp=%p", a, got);
  endtask

  task automatic test_bad_opcode();
    bq_t got, exp;
    int n0 = n_xfer;
    logic [31:0] a = $urandom;
    send_bytes(build(8'h33, 32'h0, 32'h0));
    collect(1, 0, got);
    checks++;
    if (got.size() != 1 || got[0] !== 8'h3F || n_xfer != n0) begin
      failures++; $display("FAIL badop: got %p xfers=%0d, required '{3f} 0", got, n_xfer - n0);
    end
    slv_wait = 1; slv_rdata = $urandom;
    exp = model(8'h52, slv_rdata, 1'b0, 1'b0);
    send_bytes(build(8'h52, a, 32'h0));
    collect(5, 0, got);
    checks++;
    if (got != exp || obs_addr !== a) begin
      failures++; $display("FAIL badop_next: got %p addr=%h, required %p %h", got, obs_addr, exp, a);
    end
    $display("txn bad_opcode then read addr=%h resp=%p", a, got);
  endtask

  task automatic test_reset_mid();
    bq_t got, exp, fr;
    int budget = 30;
    logic [31:0] a = $urandom, d = $urandom;
    fr = build(8'h52, $urandom, 32'h0);
    fr = fr[0:2];
    send_bytes(fr);
    srst = 1'b1; @(negedge clk); srst = 1'b0;
    checks++;
    if ({busy_o, psel_o, penable_o, tx_valid_o, rx_ready_o} !== 5'b00001 || paddr_o !== 32'h0) begin
      failures++; $display("FAIL rst_addr: {busy,psel,pen,tx_vld,rx_rdy}=%b paddr=%h, required 00001 0", {busy_o, psel_o, penable_o, tx_valid_o, rx_ready_o}, paddr_o);
    end
    slv_hang = 1'b1;
    send_bytes(build(8'h52, $urandom, 32'h0));
    while (!penable_o && budget > 0) begin @(negedge clk); budget--; end
    checks++;
    if (budget == 0) begin failures++; $display("FAIL rst_reach_access: penable=%b, required 1", penable_o); end
    srst = 1'b1; @(negedge clk); srst = 1'b0;
    checks++;
    if ({busy_o, psel_o, penable_o, tx_valid_o, rx_ready_o, pstrb_o} !== 9'b00001_0000) begin
      failures++; $display("FAIL rst_access: {busy,psel,pen,tx_vld,rx_rdy,pstrb}=%b, required 000010000", {busy_o, psel_o, penable_o, tx_valid_o, rx_ready_o, pstrb_o});
    end
    slv_hang = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (tx_valid_o !== 1'b0) begin failures++; $display("FAIL rst_no_resp: tx_valid=%b, required 0", tx_valid_o); end
    slv_wait = 0;
    exp = model(8'h57, 32'h0, 1'b0, 1'b0);
    send_bytes(build(8'h57, a, d));
    collect(1, 0, got);
    checks++;
    if (got != exp || obs_addr !== a || obs_wdata !== d || obs_write !== 1'b1) begin
      failures++; $display("FAIL rst_next: got %p addr=%h wdata=%h, required %p %h %h", got, obs_addr, obs_wdata, exp, a, d);
    end
    $display("txn reset_mid then write addr=%h data=%h resp=%p", a, d, got);
  endtask

  task automatic test_random();
    for (int t = 0; t < 24; t++) begin
      bq_t got, exp;
      int n0 = n_xfer;
      int stall = $urandom_range(0, 2);
      logic [31:0] a = $urandom, d = $urandom;
      logic [7:0] op;
      case ($urandom_range(0, 4))
        0, 1: op = 8'h57;
        2, 3: op = 8'h52;
        default: begin
          op = 8'($urandom_range(0, 255));
          if (op == 8'h57 || op == 8'h52) op = 8'h00;
        end
      endcase
      slv_wait = $urandom_range(0, 3); slv_err = 1'($urandom_range(0, 1)); slv_rdata = $urandom;
      exp = model(op, slv_rdata, slv_err, 1'b0);
      send_bytes(build(op, a, d));
      collect(exp.size(), stall, got);
      checks++;
      if (got != exp) begin failures++; $display("FAIL rand_resp[%0d]: op=%02h got %p, required %p", t, op, got, exp); end
      checks++;
      if (exp.size() == 1 && exp[0] == 8'h3F) begin
        if (n_xfer != n0) begin failures++; $display("FAIL rand_noxfer[%0d]: xfers=%0d, required 0", t, n_xfer - n0); end
      end else if (n_xfer != n0 + 1 || obs_addr !== a || obs_write !== (op == 8'h57) || unstable ||
                   obs_strb !== ((op == 8'h57) ? 4'hF : 4'h0) || (op == 8'h57 && obs_wdata !== d) ||
                   last_pen != slv_wait + 1) begin
        failures++;
        $display("FAIL rand_apb[%0d]: xfers=%0d addr=%h wdata=%h strb=%h write=%b pen=%0d unstable=%b, required 1 %h %h %h %b %0d 0",
                 t, n_xfer - n0, obs_addr, obs_wdata, obs_strb, obs_write, last_pen, unstable,
                 a, d, (op == 8'h57) ? 4'hF : 4'h0, op == 8'h57, slv_wait + 1);
      end
      $display("txn random[%0d] op=%02h addr=%h wait=%0d stall=%0d resp=%p", t, op, a, slv_wait, stall, got);
    end
    slv_err = 1'b0;
  endtask

`ifdef DHS_APB_TIMEOUT_EN
  task automatic test_timeout();
    bq_t got, exp;
    slv_hang = 1'b1;
    exp = model(8'h52, 32'h0, 1'b0, 1'b1);
    send_bytes(build(8'h52, $urandom, 32'h0));
    collect(5, 0, got);
    checks++;
    if (got != exp || last_pen != TO) begin
      failures++; $display("FAIL timeout: got %p pen_cyc=%0d, required %p %0d", got, last_pen, exp, TO);
    end
    slv_hang = 1'b0;
    $display("txn timeout resp=%p", got);
  endtask
`endif

  initial begin
    test_reset();
    test_write();
    test_read();
    test_error_backpressure();
    test_bad_opcode();
    test_reset_mid();
`ifdef DHS_APB_TIMEOUT_EN
    test_timeout();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
